// File: rtl/ps2_key_receiver_if.sv
// Key event bus from the PS/2 receiver to the display/graphics top level.
// master: receiver drives key_code/extended/released and the two pulses.
interface ps2_key_receiver_if;
   logic [7:0] key_code;
   logic       extended;
   logic       released;
   logic       interrupt;
   logic       frame_err;

   modport master (
      output key_code,
      output extended,
      output released,
      output interrupt,
      output frame_err
   );

   modport slave (
      input key_code,
      input extended,
      input released,
      input interrupt,
      input frame_err
   );
endinterface

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: sync + deglitch, 11-bit frame decode, F0/E0 folding.
// Ports: clk, reset (sync, high), ps2c/ps2d raw lines, key (event bus master).
module ps2_key_receiver #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ps2c,
   input  logic               ps2d,
   ps2_key_receiver_if.master key
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   // Timeout fires on the cycle that makes frame_err land exactly
   // TIMEOUT_CYCLES after the last accepted falling edge.
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 2);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      CHECK = 2'd2
   } state_t;

   logic                  c_s1;
   logic                  c_s2;
   logic                  d_s1;
   logic                  d_s2;
   logic [FILTER_LEN-1:0] filt_sr;
   logic                  filt_q;
   logic                  filt_d;
   logic                  fall_tick;

   always_ff @(posedge clk) begin
      if (reset) begin
         c_s1    <= 1'b1;
         c_s2    <= 1'b1;
         d_s1    <= 1'b1;
         d_s2    <= 1'b1;
         filt_sr <= '1;
         filt_q  <= 1'b1;
         filt_d  <= 1'b1;
      end else begin
         c_s1    <= ps2c;
         c_s2    <= c_s1;
         d_s1    <= ps2d;
         d_s2    <= d_s1;
         filt_sr <= {filt_sr[FILTER_LEN-2:0], c_s2};
         if (&filt_sr) begin
            filt_q <= 1'b1;
         end else if (~|filt_sr) begin
            filt_q <= 1'b0;
         end
         filt_d  <= filt_q;
      end
   end

   assign fall_tick = filt_d & ~filt_q;

   state_t        state_q;
   state_t        state_n;
   logic [3:0]    bit_cnt_q;
   logic [3:0]    bit_cnt_n;
   logic [TW-1:0] tmo_q;
   logic [TW-1:0] tmo_n;
   logic [9:0]    sh_q;
   logic [9:0]    sh_n;
   logic          rel_pend_q;
   logic          rel_pend_n;
   logic          ext_pend_q;
   logic          ext_pend_n;
   logic [7:0]    key_q;
   logic [7:0]    key_n;
   logic          ext_q;
   logic          ext_n;
   logic          rel_q;
   logic          rel_n;
   logic          int_q;
   logic          int_n;
   logic          err_q;
   logic          err_n;

   logic          frame_ok;
   logic          is_f0;
   logic          is_e0;

   // sh_q = {stop, parity, D7..D0}; odd parity over data+parity.
   assign frame_ok = (^sh_q[8:0]) & sh_q[9];
   assign is_f0    = (sh_q[7:0] == 8'hF0);
   assign is_e0    = (sh_q[7:0] == 8'hE0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         tmo_q      <= '0;
         sh_q       <= '0;
         rel_pend_q <= 1'b0;
         ext_pend_q <= 1'b0;
         key_q      <= 8'h00;
         ext_q      <= 1'b0;
         rel_q      <= 1'b0;
         int_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_n;
         bit_cnt_q  <= bit_cnt_n;
         tmo_q      <= tmo_n;
         sh_q       <= sh_n;
         rel_pend_q <= rel_pend_n;
         ext_pend_q <= ext_pend_n;
         key_q      <= key_n;
         ext_q      <= ext_n;
         rel_q      <= rel_n;
         int_q      <= int_n;
         err_q      <= err_n;
      end
   end

   always_comb begin
      state_n    = state_q;
      bit_cnt_n  = bit_cnt_q;
      tmo_n      = tmo_q;
      sh_n       = sh_q;
      rel_pend_n = rel_pend_q;
      ext_pend_n = ext_pend_q;
      key_n      = key_q;
      ext_n      = ext_q;
      rel_n      = rel_q;
      int_n      = 1'b0;
      err_n      = 1'b0;

      case (state_q)
         IDLE: begin
            if (fall_tick && !d_s2) begin
               state_n   = RECV;
               bit_cnt_n = '0;
               tmo_n     = '0;
            end
         end

         RECV: begin
            if (fall_tick) begin
               sh_n      = {d_s2, sh_q[9:1]};
               bit_cnt_n = bit_cnt_q + 4'd1;
               tmo_n     = '0;
               if (bit_cnt_q == 4'd9) begin
                  state_n = CHECK;
               end
            end else if (tmo_q == TMO_LAST) begin
               state_n    = IDLE;
               tmo_n      = '0;
               err_n      = 1'b1;
               rel_pend_n = 1'b0;
               ext_pend_n = 1'b0;
            end else begin
               tmo_n = tmo_q + 1'b1;
            end
         end

         CHECK: begin
            state_n = IDLE;
            if (!frame_ok) begin
               err_n      = 1'b1;
               rel_pend_n = 1'b0;
               ext_pend_n = 1'b0;
            end else begin
               unique case (1'b1)
                  is_f0: rel_pend_n = 1'b1;
                  is_e0: ext_pend_n = 1'b1;
                  default: begin
                     key_n      = sh_q[7:0];
                     rel_n      = rel_pend_q;
                     ext_n      = ext_pend_q;
                     rel_pend_n = 1'b0;
                     ext_pend_n = 1'b0;
                     int_n      = 1'b1;
                  end
               endcase
            end
         end

         default: state_n = IDLE;
      endcase
   end

   assign key.key_code  = key_q;
   assign key.extended  = ext_q;
   assign key.released  = rel_q;
   assign key.interrupt = int_q;
   assign key.frame_err = err_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Self-checking bench for ps2_key_receiver: directed plus random frames.
// A byte-level model tracks expected key events and pulse counts.
module tb_ps2_key_receiver;

   localparam int FL = 8;
   localparam int TO = 300;
   localparam int H  = 40;

   logic clk = 1'b0;
   logic reset;
   logic ps2c;
   logic ps2d;

   ps2_key_receiver_if key ();

   ps2_key_receiver #(
      .FILTER_LEN    (FL),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .ps2c (ps2c),
      .ps2d (ps2d),
      .key  (key)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int int_cnt = 0;
   int err_cnt = 0;
   int both_cnt = 0;
   int int_cyc = 0;
   int err_cyc = 0;
   int fall_cyc = 0;

   logic [7:0] m_key;
   logic       m_ext;
   logic       m_rel;
   logic       m_rp;
   logic       m_ep;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (key.interrupt) begin
         int_cnt <= int_cnt + 1;
         int_cyc <= cyc;
      end
      if (key.frame_err) begin
         err_cnt <= err_cnt + 1;
         err_cyc <= cyc;
      end
      if (key.interrupt && key.frame_err) both_cnt <= both_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic glitch();
      ps2c = 1'b0;
      wait_cyc(FL - 1);
      ps2c = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par,
                             input bit bad_stop, input int nbits,
                             input int glitch_bit);
      logic [10:0] fr;
      logic        par;
      par = ~(^b) ^ bad_par;
      fr  = {~bad_stop, par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2d = fr[i];
         wait_cyc(H / 2);
         if (i == glitch_bit) glitch();
         wait_cyc(H / 2);
         ps2c = 1'b0;
         fall_cyc = cyc;
         wait_cyc(H);
         ps2c = 1'b1;
      end
      ps2d = 1'b1;
   endtask

   task automatic model_frame(input logic [7:0] b, input bit ok,
                              output int e_int, output int e_err);
      e_int = 0;
      e_err = 0;
      if (!ok) begin
         e_err = 1;
         m_rp  = 1'b0;
         m_ep  = 1'b0;
      end else if (b == 8'hF0) begin
         m_rp = 1'b1;
      end else if (b == 8'hE0) begin
         m_ep = 1'b1;
      end else begin
         m_key = b;
         m_rel = m_rp;
         m_ext = m_ep;
         m_rp  = 1'b0;
         m_ep  = 1'b0;
         e_int = 1;
      end
   endtask

   task automatic outs(input string tag);
      check({tag, ".key"}, 32'(key.key_code), 32'(m_key));
      check({tag, ".rel"}, 32'(key.released), 32'(m_rel));
      check({tag, ".ext"}, 32'(key.extended), 32'(m_ext));
   endtask

   task automatic frame(input string tag, input logic [7:0] b,
                        input bit bad_par, input bit bad_stop,
                        input int glitch_bit);
      int i0, e0, ei, ee;
      i0 = int_cnt;
      e0 = err_cnt;
      send_frame(b, bad_par, bad_stop, 11, glitch_bit);
      wait_cyc(H);
      model_frame(b, !bad_par && !bad_stop, ei, ee);
      check({tag, ".int"}, 32'(int_cnt - i0), 32'(ei));
      check({tag, ".err"}, 32'(err_cnt - e0), 32'(ee));
      outs(tag);
   endtask

   initial begin
      int i0, e0;
      logic [7:0] rb;
      int r;

      reset = 1'b1;
      ps2c  = 1'b1;
      ps2d  = 1'b1;
      m_key = 8'h00;
      m_ext = 1'b0;
      m_rel = 1'b0;
      m_rp  = 1'b0;
      m_ep  = 1'b0;
      wait_cyc(5);
      check("rst.int", 32'(key.interrupt), 32'd0);
      check("rst.err", 32'(key.frame_err), 32'd0);
      outs("rst");
      reset = 1'b0;
      wait_cyc(FL + 10);

      frame("make1c", 8'h1C, 1'b0, 1'b0, -1);
      check("make1c.lat", 32'(int_cyc - fall_cyc), 32'(FL + 5));

      frame("brkF0", 8'hF0, 1'b0, 1'b0, -1);
      frame("brk1c", 8'h1C, 1'b0, 1'b0, -1);
      frame("re1c", 8'h1C, 1'b0, 1'b0, -1);

      frame("extE0", 8'hE0, 1'b0, 1'b0, -1);
      frame("extF0", 8'hF0, 1'b0, 1'b0, -1);
      frame("ext75", 8'h75, 1'b0, 1'b0, -1);

      frame("badpar", 8'h1C, 1'b1, 1'b0, -1);
      frame("good32", 8'h32, 1'b0, 1'b0, -1);
      frame("badstop", 8'h44, 1'b0, 1'b1, -1);

      i0 = int_cnt;
      e0 = err_cnt;
      ps2d = 1'b0;
      glitch();
      wait_cyc(TO + 50);
      ps2d = 1'b1;
      check("gl_idle.int", 32'(int_cnt - i0), 32'd0);
      check("gl_idle.err", 32'(err_cnt - e0), 32'd0);
      frame("gl_mid", 8'h5A, 1'b0, 1'b0, 4);

      i0 = int_cnt;
      e0 = err_cnt;
      frame("pend", 8'hF0, 1'b0, 1'b0, -1);
      send_frame(8'h2B, 1'b0, 1'b0, 5, -1);
      wait_cyc(TO + 50);
      m_rp = 1'b0;
      m_ep = 1'b0;
      check("tmo.err", 32'(err_cnt - e0), 32'd1);
      check("tmo.int", 32'(int_cnt - i0), 32'd0);
      check("tmo.lat", 32'(err_cyc - fall_cyc), 32'(FL + 3 + TO));
      outs("tmo");
      frame("after_tmo", 8'h2B, 1'b0, 1'b0, -1);

      i0 = int_cnt;
      e0 = err_cnt;
      send_frame(8'h66, 1'b0, 1'b0, 5, -1);
      reset = 1'b1;
      wait_cyc(3);
      reset = 1'b0;
      m_key = 8'h00;
      m_ext = 1'b0;
      m_rel = 1'b0;
      m_rp  = 1'b0;
      m_ep  = 1'b0;
      outs("midrst");
      wait_cyc(TO + 50);
      check("midrst.int", 32'(int_cnt - i0), 32'd0);
      check("midrst.err", 32'(err_cnt - e0), 32'd0);
      outs("midrst2");

      for (int k = 0; k < 30; k++) begin
         r = $urandom_range(0, 9);
         if (r == 0) rb = 8'hF0;
         else if (r == 1) rb = 8'hE0;
         else rb = 8'($urandom);
         frame($sformatf("rnd%0d", k), rb,
               $urandom_range(0, 7) == 0,
               $urandom_range(0, 11) == 0,
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1);
      end

      check("never_both", 32'(both_cnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
